amg_pipe_approx_mul: RTL

AMG_PIPE_APPROX_MUL -- requirements
Module: amg_pipe_approx_mul

---
 rtl/amg_pipe_approx_mul.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/amg_pipe_approx_mul.sv
// Two-stage pipelined unsigned multiplier with exact/approximate modes per transaction.
// Optional error statistics (err_cnt/err_max) are built when AMG_MUL_ERR_STATS_EN is defined.
module amg_pipe_approx_mul #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned TRUNC_COLS = 2,
    parameter int unsigned OR_COLS    = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    input  logic                 mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 p_mode
`ifdef AMG_MUL_ERR_STATS_EN
    ,
    output logic [15:0]          err_cnt,
    output logic [2*WIDTH-1:0]   err_max
`endif
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned NPAIR = WIDTH / 2;

    function automatic logic [PW-1:0] col_mask(input int unsigned lo, input int unsigned hi);
        logic [PW-1:0] m;
        m = '0;
        for (int unsigned c = 0; c < PW; c++) begin
            m[c] = (c >= lo) && (c < hi);
        end
        return m;
    endfunction

    localparam logic [PW-1:0] MASK_OR = col_mask(TRUNC_COLS, OR_COLS);
    localparam logic [PW-1:0] MASK_HI = col_mask(OR_COLS, PW);

    logic               w_en;
    logic [PW-1:0]      w_pair [NPAIR];
    logic [PW-1:0]      w_sum;

    logic               r_v1;
    logic               r_v2;
    logic               r_mode1;
    logic [PW-1:0]      r_pair [NPAIR];
    logic [PW-1:0]      r_p;
    logic               r_p_mode;

    assign w_en      = !r_v2 || out_ready;
    assign in_ready  = w_en;
    assign out_valid = r_v2;
    assign p         = r_p;
    assign p_mode    = r_p_mode;

    // Row-pair reduction: exact add, or truncate / OR-merge / half-add by column band.
    always_comb begin
        logic [PW-1:0] a;
        logic [PW-1:0] b;
        for (int unsigned k = 0; k < NPAIR; k++) begin
            a = x[2*k]   ? (PW'(y) << (2*k))     : '0;
            b = x[2*k+1] ? (PW'(y) << (2*k + 1)) : '0;
            if (mode) begin
                w_pair[k] = ((a | b) & MASK_OR) + (a & MASK_HI) + (b & MASK_HI);
            end else begin
                w_pair[k] = a + b;
            end
        end
    end

    always_comb begin
        w_sum = '0;
        for (int unsigned k = 0; k < NPAIR; k++) begin
            w_sum = w_sum + r_pair[k];
        end
    end

    // Both stages share one advance enable; data only captured behind a valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1     <= 1'b0;
            r_v2     <= 1'b0;
            r_mode1  <= 1'b0;
            r_p      <= '0;
            r_p_mode <= 1'b0;
            for (int unsigned k = 0; k < NPAIR; k++) begin
                r_pair[k] <= '0;
            end
        end else if (w_en) begin
            r_v1 <= in_valid;
            r_v2 <= r_v1;
            if (in_valid) begin
                r_mode1 <= mode;
                for (int unsigned k = 0; k < NPAIR; k++) begin
                    r_pair[k] <= w_pair[k];
                end
            end
            if (r_v1) begin
                r_p      <= w_sum;
                r_p_mode <= r_mode1;
            end
        end
    end

`ifdef AMG_MUL_ERR_STATS_EN
    logic [PW-1:0]      r_exact1;
    logic [PW-1:0]      r_exact2;
    logic [15:0]        r_err_cnt;
    logic [PW-1:0]      r_err_max;
    logic [PW-1:0]      w_diff;

    assign err_cnt = r_err_cnt;
    assign err_max = r_err_max;

    always_comb begin
        w_diff = (r_exact2 >= r_p) ? (r_exact2 - r_p) : (r_p - r_exact2);
    end

    // Reference product travels alongside the pair rows; stats update on output handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_exact1  <= '0;
            r_exact2  <= '0;
            r_err_cnt <= '0;
            r_err_max <= '0;
        end else begin
            if (w_en && in_valid) begin
                r_exact1 <= PW'(x) * PW'(y);
            end
            if (w_en && r_v1) begin
                r_exact2 <= r_exact1;
            end
            if (r_v2 && out_ready && r_p_mode && (r_p != r_exact2)) begin
                if (r_err_cnt != 16'hFFFF) begin
                    r_err_cnt <= r_err_cnt + 16'd1;
                end
                if (w_diff > r_err_max) begin
                    r_err_max <= w_diff;
                end
            end
        end
    end
`endif

endmodule
